// File: rtl/board_engine_if.sv
// Request/response bundle between the key path, board_engine and the display renderer.
interface board_engine_if;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic        ready;
    logic        load_en;
    logic [63:0] load_board;
    logic [63:0] board;
    logic [15:0] score;
    logic        done;
    logic        win;
    logic        game_over;

    modport slave (
        input  move_valid, move_dir, load_en, load_board,
        output ready, board, score, done, win, game_over
    );

    modport master (
        output move_valid, move_dir, load_en, load_board,
        input  ready, board, score, done, win, game_over
    );
endinterface

// File: rtl/board_engine.sv
// 2048 game-state core: holds the 4x4 board, slides/merges one line per cycle, publishes flags.
// Optional tile spawning (LFSR, INIT0/INIT1/SPAWN states) is enabled by defining BOARD_SPAWN_EN.
module board_engine #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic          CLK,
    input  logic          RST,
    board_engine_if.slave bus
);

    if (SEED == 16'h0000) begin : g_seed_check
        $error("board_engine: SEED must be nonzero");
    end

`ifdef BOARD_SPAWN_EN
    typedef enum logic [3:0] {
        INIT0, INIT1, IDLE, SLIDE0, SLIDE1, SLIDE2, SLIDE3, SPAWN, CHECK
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, SLIDE0, SLIDE1, SLIDE2, SLIDE3, CHECK
    } state_t;
`endif

    state_t      state;
    state_t      slide_next;
    logic [63:0] board_q;
    logic [15:0] score_q;
    logic        ready_q;
    logic        done_q;
    logic        win_q;
    logic        over_q;
    logic [1:0]  dir_q;

    logic [1:0]       line_sel;
    logic [3:0][3:0]  idx;
    logic [3:0][3:0]  line_in;
    logic [3:0][3:0]  line_out;
    logic [4:0][3:0]  packed_n;
    logic [16:0]      add;
    logic [16:0]      score_sum;
    logic [15:0]      score_sat;
    logic             any_zero;
    logic             any_pair;
    logic             any_win;

    function automatic logic [3:0] cell_at(input logic [63:0] b, input logic [3:0] i);
        return b[{i, 2'b00} +: 4];
    endfunction

    always_comb begin
        line_sel   = 2'd0;
        slide_next = CHECK;
        case (state)
            SLIDE0: begin line_sel = 2'd0; slide_next = SLIDE1; end
            SLIDE1: begin line_sel = 2'd1; slide_next = SLIDE2; end
            SLIDE2: begin line_sel = 2'd2; slide_next = SLIDE3; end
`ifdef BOARD_SPAWN_EN
            SLIDE3: begin line_sel = 2'd3; slide_next = SPAWN; end
`else
            SLIDE3: begin line_sel = 2'd3; slide_next = CHECK; end
`endif
            default: ;
        endcase
    end

    // Element 0 of a line is the cell tiles slide toward.
    always_comb begin
        logic [1:0] mm;
        logic [1:0] pj;
        logic [1:0] oj;
        logic       skip;
        logic [3:0] v;
        logic [3:0] e;
        mm       = '0;
        pj       = '0;
        oj       = '0;
        skip     = 1'b0;
        v        = '0;
        e        = '0;
        idx      = '0;
        line_in  = '0;
        line_out = '0;
        packed_n = '0;
        add      = '0;
        for (int unsigned m = 0; m < 4; m++) begin
            mm = 2'(m);
            case (dir_q)
                2'd0:    idx[mm] = {mm, line_sel};
                2'd1:    idx[mm] = {~mm, line_sel};
                2'd2:    idx[mm] = {line_sel, mm};
                default: idx[mm] = {line_sel, ~mm};
            endcase
            line_in[mm] = cell_at(board_q, idx[mm]);
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (line_in[2'(i)] != 4'd0) begin
                packed_n[{1'b0, pj}] = line_in[2'(i)];
                pj = pj + 2'd1;
            end
        end
        // skip keeps a freshly merged tile from merging again this move.
        for (int unsigned i = 0; i < 4; i++) begin
            v = packed_n[3'(i)];
            if (skip) begin
                skip = 1'b0;
            end else if (v != 4'd0) begin
                if (v == packed_n[3'(i) + 3'd1]) begin
                    e            = (v == 4'hF) ? 4'hF : v + 4'd1;
                    line_out[oj] = e;
                    add          = add + (17'd1 << e);
                    skip         = 1'b1;
                end else begin
                    line_out[oj] = v;
                end
                oj = oj + 2'd1;
            end
        end
    end

    assign score_sum = {1'b0, score_q} + add;
    assign score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];

    always_comb begin
        logic [3:0] v;
        v        = '0;
        any_zero = 1'b0;
        any_pair = 1'b0;
        any_win  = 1'b0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                v = cell_at(board_q, 4'(4 * r + c));
                if (v == 4'd0)  any_zero = 1'b1;
                if (v == 4'd11) any_win  = 1'b1;
                if (c < 3 && v != 4'd0 && v == cell_at(board_q, 4'(4 * r + c + 1)))
                    any_pair = 1'b1;
                if (r < 3 && v != 4'd0 && v == cell_at(board_q, 4'(4 * r + c + 4)))
                    any_pair = 1'b1;
            end
        end
    end

`ifdef BOARD_SPAWN_EN
    logic [15:0] lfsr;
    logic        changed_q;
    logic        spawn_found;
    logic [3:0]  spawn_idx;
    logic [3:0]  spawn_val;

    always_comb begin
        logic [3:0] p;
        p           = '0;
        spawn_found = 1'b0;
        spawn_idx   = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            p = lfsr[3:0] + 4'(i);
            if (!spawn_found && cell_at(board_q, p) == 4'd0) begin
                spawn_found = 1'b1;
                spawn_idx   = p;
            end
        end
        spawn_val = (lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
    end
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
`ifdef BOARD_SPAWN_EN
            state     <= INIT0;
            ready_q   <= 1'b0;
            lfsr      <= SEED;
            changed_q <= 1'b0;
`else
            state     <= IDLE;
            ready_q   <= 1'b1;
`endif
            board_q   <= '0;
            score_q   <= '0;
            win_q     <= 1'b0;
            over_q    <= 1'b0;
            done_q    <= 1'b0;
            dir_q     <= '0;
        end else begin
            done_q <= 1'b0;
`ifdef BOARD_SPAWN_EN
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`endif
            case (state)
`ifdef BOARD_SPAWN_EN
                INIT0: begin
                    if (spawn_found) board_q[{spawn_idx, 2'b00} +: 4] <= spawn_val;
                    state <= INIT1;
                end
                INIT1: begin
                    if (spawn_found) board_q[{spawn_idx, 2'b00} +: 4] <= spawn_val;
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                SPAWN: begin
                    if (changed_q && spawn_found)
                        board_q[{spawn_idx, 2'b00} +: 4] <= spawn_val;
                    state <= CHECK;
                end
`endif
                IDLE: begin
                    if (bus.load_en) begin
                        board_q <= bus.load_board;
                        score_q <= '0;
                        win_q   <= 1'b0;
                        ready_q <= 1'b0;
                        state   <= CHECK;
                    end else if (bus.move_valid) begin
                        dir_q   <= bus.move_dir;
                        ready_q <= 1'b0;
`ifdef BOARD_SPAWN_EN
                        changed_q <= 1'b0;
`endif
                        state   <= SLIDE0;
                    end
                end
                SLIDE0, SLIDE1, SLIDE2, SLIDE3: begin
                    for (int unsigned m = 0; m < 4; m++)
                        board_q[{idx[2'(m)], 2'b00} +: 4] <= line_out[2'(m)];
                    score_q <= score_sat;
`ifdef BOARD_SPAWN_EN
                    if (line_out != line_in) changed_q <= 1'b1;
`endif
                    state <= slide_next;
                end
                CHECK: begin
                    over_q  <= !any_zero && !any_pair;
                    win_q   <= win_q | any_win;
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.board     = board_q;
    assign bus.score     = score_q;
    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.win       = win_q;
    assign bus.game_over = over_q;

endmodule

// File: tb/tb_board_engine.sv
// Directed bench for board_engine; spawn-specific checks compile in when BOARD_SPAWN_EN is defined.
module tb_board_engine;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    board_engine_if bus();

    board_engine #(.SEED(16'hACE1)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus.slave)
    );

`ifdef BOARD_SPAWN_EN
    localparam int MOVE_LAT = 6;
    localparam logic RST_READY = 1'b0;
`else
    localparam int MOVE_LAT = 5;
    localparam logic RST_READY = 1'b1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int nonzero(input logic [63:0] b);
        int n = 0;
        for (int i = 0; i < 16; i++) if (b[4*i +: 4] != 4'd0) n++;
        return n;
    endfunction

    task automatic wait_ready();
        int t = 0;
        while (!bus.ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("ready_seen", 64'(bus.ready), 64'd1);
    endtask

    task automatic finish_op(input string tag, input int lat);
        int first = 0;
        int hits  = 0;
        for (int i = 1; i <= lat + 1; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                hits++;
                if (first == 0) first = i;
            end
        end
        check({tag, "_done_at"}, 64'(first), 64'(lat));
        check({tag, "_done_cnt"}, 64'(hits), 64'd1);
    endtask

    task automatic do_load(input logic [63:0] b);
        wait_ready();
        bus.load_board = b;
        bus.load_en    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.load_en = 1'b0;
        finish_op("load", 1);
    endtask

    task automatic do_move(input string tag, input logic [1:0] dir);
        wait_ready();
        bus.move_dir   = dir;
        bus.move_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.move_valid = 1'b0;
        check({tag, "_busy"}, 64'(bus.ready), 64'd0);
        finish_op(tag, MOVE_LAT);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hits;
        logic ok;
        bus.move_valid = 1'b0;
        bus.move_dir   = 2'd0;
        bus.load_en    = 1'b0;
        bus.load_board = '0;

        repeat (2) @(negedge clk);
        check("rst_board", bus.board, 64'd0);
        check("rst_score", 64'(bus.score), 64'd0);
        check("rst_done",  64'(bus.done), 64'd0);
        check("rst_win",   64'(bus.win), 64'd0);
        check("rst_over",  64'(bus.game_over), 64'd0);
        rst_n = 1'b1;
        check("rst_ready", 64'(bus.ready), 64'(RST_READY));

`ifdef BOARD_SPAWN_EN
        wait_ready();
        check("init_tiles", 64'(nonzero(bus.board)), 64'd2);
        ok = 1'b1;
        for (int i = 0; i < 16; i++)
            if (bus.board[4*i +: 4] > 4'd2) ok = 1'b0;
        check("init_values", 64'(ok), 64'd1);
`endif

        // row0 = 1,1,2,2 -> 2,3,0,0 ; 4 + 8
        do_load(64'h2211);
        check("l1_over", 64'(bus.game_over), 64'd0);
        do_move("l1", 2'd2);
`ifndef BOARD_SPAWN_EN
        check("l1_board", bus.board, 64'h0032);
`endif
        check("l1_score", 64'(bus.score), 64'd12);

`ifndef BOARD_SPAWN_EN
        // 1,1,1,1 -> 2,2,0,0 then right -> 0,0,0,3
        do_load(64'h1111);
        do_move("l2", 2'd2);
        check("l2_board", bus.board, 64'h0022);
        check("l2_score", 64'(bus.score), 64'd8);
        do_move("r2", 2'd3);
        check("r2_board", bus.board, 64'h3000);
        check("r2_score", 64'(bus.score), 64'd16);

        // column 0 = 0,2,0,2 top to bottom
        do_load(64'h0002_0000_0002_0000);
        do_move("u3", 2'd0);
        check("u3_board", bus.board, 64'h3);
        check("u3_score", 64'(bus.score), 64'd8);
        do_move("d3", 2'd1);
        check("d3_board", bus.board, 64'h0003_0000_0000_0000);
        check("d3_score", 64'(bus.score), 64'd8);

        // exponent 15 merges saturate both the tile and the score
        do_load(64'hFFFF);
        do_move("sat", 2'd2);
        check("sat_board", bus.board, 64'h00FF);
        check("sat_score", 64'(bus.score), 64'hFFFF);
`endif

        do_load(64'h1212_2121_1212_2121);
        check("ck_over", 64'(bus.game_over), 64'd1);
        check("ck_win",  64'(bus.win), 64'd0);
        do_move("ck_mv", 2'd2);
        check("ck_mv_board", bus.board, 64'h1212_2121_1212_2121);
        check("ck_mv_score", 64'(bus.score), 64'd0);

        do_load(64'hAA);
        check("w_over0", 64'(bus.game_over), 64'd0);
        do_move("w", 2'd2);
        check("w_cell", 64'(bus.board[3:0]), 64'd11);
        check("w_win", 64'(bus.win), 64'd1);
        check("w_score", 64'(bus.score), 64'd2048);

`ifdef BOARD_SPAWN_EN
        do_load(64'h1);
        do_move("sp", 2'd3);
        check("sp_cell", 64'(bus.board[15:12]), 64'd1);
        check("sp_count", 64'(nonzero(bus.board)), 64'd2);
        do_load(64'h1);
        do_move("nsp", 2'd2);
        check("nsp_board", bus.board, 64'h1);
`endif

        // reset while the engine sits in SLIDE2
        do_load(64'h1111);
        wait_ready();
        bus.move_dir   = 2'd2;
        bus.move_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.move_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("ab_pre_score", 64'(bus.score), 64'd8);
        rst_n = 1'b0;
        #1;
        check("ab_board", bus.board, 64'd0);
        check("ab_score", 64'(bus.score), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("ab_ready", 64'(bus.ready), 64'(RST_READY));
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) hits++;
        end
        check("ab_no_done", 64'(hits), 64'd0);
        wait_ready();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/board_engine.md
# board_engine

Game-state core of the 2048 design. It sits between the debounced key path (chattering_remover) and the `display` renderer. It holds the 4x4 tile board and executes one move per accepted request by sliding and merging lines. It optionally spawns a new tile, and it publishes the board, score, win and game-over flags for rendering.

## Interface
Parameters:
- SEED, 16'hACE1, reset value of the spawn LFSR; must be nonzero.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- move_valid  in  1  move request.
- move_dir  in  2  direction: 0 up, 1 down, 2 left, 3 right.
- ready  out  1  high only in IDLE; a request is accepted on an edge where ready & move_valid.
- load_en  in  1  debug board load; sampled only in IDLE; has priority over move_valid.
- load_board  in  64  board image written on load.
- board  out  64  cell (r,c) is at bits [4*(4r+c)+3 : 4*(4r+c)]; r=0 is the top row, c=0 is the left column.
- score  out  16  accumulated merge score.
- done  out  1  one-cycle pulse at the end of each move or load.
- win  out  1  sticky: some cell has reached exponent 11 (2048).
- game_over  out  1  no empty cell and no equal orthogonal neighbours.

## Operation
- Cell encoding: value 0 means an empty cell; value e means tile 2^e. A merged exponent is e+1, saturating at 15.
- FSM states: INIT0, INIT1 (macro only), IDLE, SLIDE0..SLIDE3, SPAWN (macro only), CHECK.
- Line extraction for SLIDEk, elements listed front to back:
  - left: row k, c=0..3.
  - right: row k, c=3..0.
  - up: column k, r=0..3.
  - down: column k, r=3..0.
- Line compress:
  - Remove empty cells.
  - Scanning from the front, merge each equal adjacent pair once. A merged result never merges again in the same move.
  - Pack results toward the front and fill the remainder with 0.
  - Write the line back in the same order it was extracted.
- Score: each merge adds 2^(new exponent). The 16-bit sum saturates at 16'hFFFF.
- A `changed` flag is set if any written line differs from its original.
- Load: in IDLE with load_en high, board <= load_board, score <= 0, win <= 0, then go to CHECK.
- CHECK:
  - game_over <= (no zero cell) & (no horizontally or vertically adjacent equal nonzero pair).
  - win <= win | (any cell == 11).
  - done <= 1; go to IDLE.
- Moves are accepted while game_over=1; the move simply produces no change.

## Timing
- Reset (RST low), asynchronous:
  - board=0, score=0, win=0, game_over=0, done=0, LFSR=SEED.
  - state = INIT0 with the macro, IDLE without it. ready=0 in INIT states.
- Accept edge E0 moves the FSM to SLIDE0. Edges E1..E4 write lines 0..3.
- Without the macro, E5 executes CHECK. done and ready are both high in the cycle after E5.
- With the macro, E5 executes SPAWN and E6 executes CHECK.
- Load accept edge E0 goes to CHECK. E1 executes CHECK, and done is high in the cycle after E1.
- move_valid is ignored outside IDLE. There is no request queue, so the source must hold or re-issue the request.
- Reset mid-operation aborts immediately. No partial score is kept.

## Configuration
BOARD_SPAWN_EN:
- Defined:
  - LFSR x^16+x^14+x^13+x^11 (Fibonacci) advances every cycle.
  - Spawn picks the first empty cell scanning from index lfsr[3:0] upward, mod 16.
  - Spawn value is 2 if lfsr[7:4]==0, else 1.
  - INIT0 and INIT1 each spawn one tile after reset.
  - SPAWN runs after every move. It writes only if changed=1 and an empty cell exists.
- Undefined:
  - No LFSR, INIT or SPAWN states.
  - Board starts all zero, and moves are fully deterministic.

## Test plan
- No macro: load row0 = 1,1,2,2 (rest 0), move left. Required: row0 = 2,3,0,0, score=12, done exactly one cycle high, in the cycle after E5.
- No macro: row0 = 1,1,1,1, move left. Required: 2,2,0,0, score=8. Then move right. Required: 0,0,0,3, score=16.
- No macro: column 0 = 0,2,0,2 top to bottom, move up. Required: column 0 = 3,0,0,0, score=8. Then move down. Required: column 0 = 0,0,0,3.
- No macro: load a full checkerboard of 1/2. Required: game_over=1 after the load's done. Load cells (0,0)=10 and (0,1)=10, move left. Required: (0,0)=11, win=1, score=2048.
- Macro, SEED=16'hACE1:
  - After reset, exactly 2 nonzero cells, each 1 or 2, before ready rises.
  - A changing move adds exactly one nonzero cell.
  - A non-changing move leaves the board identical.
- Reset abort: assert RST low during SLIDE2. Required: same-cycle board=0 and score=0. After release, INIT or IDLE re-entered per macro, and no spurious done.
